// File: rtl/chunk_addr_looper_if.sv
// Offset-in / row-command-out bundle for chunk_addr_looper.
// master = offset producer and command consumer; slave = the looper itself.
interface chunk_addr_looper_if #(
  parameter int unsigned WBW    = 16,
  parameter int unsigned DIM    = 3,
  parameter int unsigned N_ICFG = 4,
  parameter int unsigned GBW    = 32,
  parameter int unsigned LBW    = 8
);
  localparam int unsigned ICFG_BW = $clog2(N_ICFG + 1);

  logic                                   i_mofs_rdy;
  logic                                   i_mofs_ack;
  logic                                   i_which;
  logic [DIM-1:0][WBW-1:0]                i_mofs;
  logic [ICFG_BW-1:0]                     i_id;
  logic [N_ICFG-1:0][GBW-1:0]             i_mlinear;
  logic [N_ICFG-1:0][DIM-1:0][GBW-1:0]    i_mstride;
  logic [N_ICFG-1:0][LBW-1:0]             i_row_len;
  logic [N_ICFG-1:0][LBW-1:0]             i_row_cnt;
  logic [N_ICFG-1:0][WBW-1:0]             i_mbound;

  logic                                   o_cmd_rdy;
  logic                                   o_cmd_ack;
  logic                                   o_cmd_which;
  logic [GBW-1:0]                         o_cmd_addr;
  logic [LBW-1:0]                         o_cmd_len;
  logic                                   o_cmd_pad;
  logic                                   o_cmd_last;

  modport master (
    output i_mofs_rdy, i_which, i_mofs, i_id, i_mlinear, i_mstride, i_row_len, i_row_cnt,
           i_mbound, o_cmd_ack,
    input  i_mofs_ack, o_cmd_rdy, o_cmd_which, o_cmd_addr, o_cmd_len, o_cmd_pad, o_cmd_last
  );

  modport slave (
    input  i_mofs_rdy, i_which, i_mofs, i_id, i_mlinear, i_mstride, i_row_len, i_row_cnt,
           i_mbound, o_cmd_ack,
    output i_mofs_ack, o_cmd_rdy, o_cmd_which, o_cmd_addr, o_cmd_len, o_cmd_pad, o_cmd_last
  );
endinterface

// File: rtl/chunk_addr_looper.sv
// Turns a chunk-origin offset into one DRAM row command per row of the chunk.
// Optional BOUNDARY_PAD_EN: flag rows whose row coordinate lies outside i_mbound.
module chunk_addr_looper #(
  parameter int unsigned WBW    = 16,
  parameter int unsigned DIM    = 3,
  parameter int unsigned N_ICFG = 4,
  parameter int unsigned GBW    = 32,
  parameter int unsigned LBW    = 8
) (
  input logic                 i_clk,
  input logic                 i_rst,
  chunk_addr_looper_if.slave  bus_io
);
  localparam int unsigned ICFG_BW = $clog2(N_ICFG + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StEmit = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [LBW-1:0] r_q, r_d;
  logic [LBW-1:0] cnt_m1_q, cnt_m1_d;
  logic [LBW-1:0] len_q, len_d;
  logic           which_q, which_d;
  logic [GBW-1:0] addr_q, addr_d;
  logic [GBW-1:0] row_stride_q, row_stride_d;

  logic                    emit;
  logic                    accept;
  logic                    last;
  logic [GBW-1:0]          lin_sel;
  logic [DIM-1:0][GBW-1:0] stride_sel;
  logic [LBW-1:0]          len_sel;
  logic [LBW-1:0]          cnt_sel;
  logic [GBW-1:0]          base;

  assign emit   = (state_q == StEmit);
  assign accept = bus_io.i_mofs_rdy && (state_q == StIdle);
  assign last   = emit && (r_q == cnt_m1_q);

  // Config select by compare rather than direct index: i_id can exceed N_ICFG-1.
  always_comb begin
    lin_sel    = '0;
    stride_sel = '0;
    len_sel    = '0;
    cnt_sel    = '0;
    for (int i = 0; i < N_ICFG; i++) begin
      if (bus_io.i_id == ICFG_BW'(i)) begin
        lin_sel    = bus_io.i_mlinear[i];
        stride_sel = bus_io.i_mstride[i];
        len_sel    = bus_io.i_row_len[i];
        cnt_sel    = bus_io.i_row_cnt[i];
      end
    end
  end

  always_comb begin
    base = lin_sel;
    for (int d = 0; d < DIM; d++) begin
      base = base + GBW'(bus_io.i_mofs[d]) * stride_sel[d];
    end
  end

`ifdef BOUNDARY_PAD_EN
  logic [WBW-1:0] bound_sel;
  logic [WBW-1:0] pos_q, pos_d;
  logic [WBW-1:0] bound_q, bound_d;

  always_comb begin
    bound_sel = '0;
    for (int i = 0; i < N_ICFG; i++) begin
      if (bus_io.i_id == ICFG_BW'(i)) begin
        bound_sel = bus_io.i_mbound[i];
      end
    end
  end

  // Row coordinate wraps mod 2^WBW, so a negative origin reads as huge and pads.
  always_comb begin
    pos_d   = pos_q;
    bound_d = bound_q;
    if (accept) begin
      pos_d   = bus_io.i_mofs[DIM-2];
      bound_d = bound_sel;
    end else if (emit && bus_io.o_cmd_ack && !last) begin
      pos_d = pos_q + WBW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pos_q   <= '0;
      bound_q <= '0;
    end else begin
      pos_q   <= pos_d;
      bound_q <= bound_d;
    end
  end

  assign bus_io.o_cmd_pad = emit && (pos_q >= bound_q);
`else
  logic unused_mbound;
  assign unused_mbound    = ^bus_io.i_mbound;
  assign bus_io.o_cmd_pad = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    cnt_m1_d     = cnt_m1_q;
    len_d        = len_q;
    which_d      = which_q;
    addr_d       = addr_q;
    row_stride_d = row_stride_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StEmit;
          r_d          = '0;
          cnt_m1_d     = cnt_sel - LBW'(1);
          len_d        = len_sel;
          which_d      = bus_io.i_which;
          addr_d       = base;
          row_stride_d = stride_sel[DIM-2];
        end
      end
      StEmit: begin
        if (bus_io.o_cmd_ack) begin
          if (last) begin
            state_d = StIdle;
          end else begin
            r_d    = r_q + LBW'(1);
            addr_d = addr_q + row_stride_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StIdle;
      r_q          <= '0;
      cnt_m1_q     <= '0;
      len_q        <= '0;
      which_q      <= 1'b0;
      addr_q       <= '0;
      row_stride_q <= '0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      cnt_m1_q     <= cnt_m1_d;
      len_q        <= len_d;
      which_q      <= which_d;
      addr_q       <= addr_d;
      row_stride_q <= row_stride_d;
    end
  end

  assign bus_io.i_mofs_ack  = accept;
  assign bus_io.o_cmd_rdy   = emit;
  assign bus_io.o_cmd_which = which_q;
  assign bus_io.o_cmd_addr  = addr_q;
  assign bus_io.o_cmd_len   = len_q;
  assign bus_io.o_cmd_last  = last;

endmodule

// File: tb/tb_chunk_addr_looper.sv
// Directed self-checking bench for chunk_addr_looper (DIM=2, two configs).
module tb_chunk_addr_looper;
  localparam int unsigned WBW    = 16;
  localparam int unsigned DIM    = 2;
  localparam int unsigned N_ICFG = 2;
  localparam int unsigned GBW    = 32;
  localparam int unsigned LBW    = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  chunk_addr_looper_if #(
    .WBW(WBW), .DIM(DIM), .N_ICFG(N_ICFG), .GBW(GBW), .LBW(LBW)
  ) bus ();

  chunk_addr_looper #(
    .WBW(WBW), .DIM(DIM), .N_ICFG(N_ICFG), .GBW(GBW), .LBW(LBW)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus_io (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int idx, input logic [31:0] lin, input logic [31:0] s0,
                         input logic [31:0] s1, input logic [7:0] len, input logic [7:0] cnt,
                         input logic [15:0] bound);
    bus.i_mlinear[idx]    = lin;
    bus.i_mstride[idx][0] = s0;
    bus.i_mstride[idx][1] = s1;
    bus.i_row_len[idx]    = len;
    bus.i_row_cnt[idx]    = cnt;
    bus.i_mbound[idx]     = bound;
  endtask

  task automatic offer(input logic [1:0] id, input logic which, input logic [15:0] m0,
                       input logic [15:0] m1);
    bus.i_id       = id;
    bus.i_which    = which;
    bus.i_mofs[0]  = m0;
    bus.i_mofs[1]  = m1;
    bus.i_mofs_rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_mofs_rdy = 1'b0;
    bus.o_cmd_ack  = 1'b0;
    offer(2'd0, 1'b0, 16'd0, 16'd0);
    bus.i_mofs_rdy = 1'b0;
    #1;
    n_checks++; if (bus.o_cmd_rdy !== 1'b0) $display("FAIL reset_rdy: got %b want 0", bus.o_cmd_rdy); else n_pass++;
    n_checks++; if (bus.o_cmd_addr !== 32'd0) $display("FAIL reset_addr: got %0d want 0", bus.o_cmd_addr); else n_pass++;
    n_checks++; if (bus.o_cmd_last !== 1'b0) $display("FAIL reset_last: got %b want 0", bus.o_cmd_last); else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    bus.i_mofs_rdy = 1'b1;
    #1;
    n_checks++; if (bus.i_mofs_ack !== 1'b1) $display("FAIL reset_ack_follow: got %b want 1", bus.i_mofs_ack); else n_pass++;
    bus.i_mofs_rdy = 1'b0;
    #1;
    n_checks++; if (bus.i_mofs_ack !== 1'b0) $display("FAIL reset_ack_low: got %b want 0", bus.i_mofs_ack); else n_pass++;
  endtask

  task automatic test_basic();
    offer(2'd1, 1'b1, 16'd3, 16'd5);
    bus.o_cmd_ack = 1'b0;
    #1;
    n_checks++; if (bus.i_mofs_ack !== 1'b1) $display("FAIL basic_accept: got %b want 1", bus.i_mofs_ack); else n_pass++;
    tick();
    n_checks++; if (bus.o_cmd_rdy !== 1'b1) $display("FAIL basic_rdy0: got %b want 1", bus.o_cmd_rdy); else n_pass++;
    n_checks++; if (bus.o_cmd_addr !== 32'd297) $display("FAIL basic_addr0: got %0d want 297", bus.o_cmd_addr); else n_pass++;
    n_checks++; if (bus.o_cmd_len !== 8'd4) $display("FAIL basic_len: got %0d want 4", bus.o_cmd_len); else n_pass++;
    n_checks++; if (bus.o_cmd_which !== 1'b1) $display("FAIL basic_which: got %b want 1", bus.o_cmd_which); else n_pass++;
    n_checks++; if (bus.o_cmd_last !== 1'b0) $display("FAIL basic_last0: got %b want 0", bus.o_cmd_last); else n_pass++;
    n_checks++; if (bus.i_mofs_ack !== 1'b0) $display("FAIL basic_ack_emit: got %b want 0", bus.i_mofs_ack); else n_pass++;
    bus.i_mofs_rdy = 1'b0;
    bus.o_cmd_ack  = 1'b1;
    tick();
    n_checks++; if (bus.o_cmd_addr !== 32'd361) $display("FAIL basic_addr1: got %0d want 361", bus.o_cmd_addr); else n_pass++;
    n_checks++; if (bus.o_cmd_last !== 1'b0) $display("FAIL basic_last1: got %b want 0", bus.o_cmd_last); else n_pass++;
    tick();
    n_checks++; if (bus.o_cmd_addr !== 32'd425) $display("FAIL basic_addr2: got %0d want 425", bus.o_cmd_addr); else n_pass++;
    n_checks++; if (bus.o_cmd_last !== 1'b1) $display("FAIL basic_last2: got %b want 1", bus.o_cmd_last); else n_pass++;
    bus.i_mofs_rdy = 1'b1;
    #1;
    n_checks++; if (bus.i_mofs_ack !== 1'b0) $display("FAIL basic_ack_lastcyc: got %b want 0", bus.i_mofs_ack); else n_pass++;
    tick();
    n_checks++; if (bus.o_cmd_rdy !== 1'b0) $display("FAIL basic_done: got %b want 0", bus.o_cmd_rdy); else n_pass++;
    n_checks++; if (bus.i_mofs_ack !== 1'b1) $display("FAIL basic_ack_back: got %b want 1", bus.i_mofs_ack); else n_pass++;
    bus.i_mofs_rdy = 1'b0;
    bus.o_cmd_ack  = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    int n_cmd = 0;
    int budget = 20;
    offer(2'd1, 1'b0, 16'd3, 16'd5);
    tick();
    bus.i_mofs_rdy = 1'b0;
    bus.o_cmd_ack  = 1'b1;
    n_cmd++;
    tick();
    bus.o_cmd_ack = 1'b0;
    repeat (5) begin
      n_checks++; if (bus.o_cmd_addr !== 32'd361) $display("FAIL stall_addr: got %0d want 361", bus.o_cmd_addr); else n_pass++;
      n_checks++; if (bus.o_cmd_last !== 1'b0) $display("FAIL stall_last: got %b want 0", bus.o_cmd_last); else n_pass++;
      tick();
    end
    n_checks++; if (bus.o_cmd_which !== 1'b0) $display("FAIL stall_which: got %b want 0", bus.o_cmd_which); else n_pass++;
    bus.o_cmd_ack = 1'b1;
    while (bus.o_cmd_rdy === 1'b1 && budget > 0) begin
      n_cmd++;
      budget--;
      tick();
    end
    bus.o_cmd_ack = 1'b0;
    n_checks++; if (n_cmd != 3) $display("FAIL stall_count: got %0d want 3", n_cmd); else n_pass++;
    tick();
  endtask

  task automatic test_single();
    set_cfg(0, 32'd1000, 32'd2, 32'd1, 8'd7, 8'd1, 16'd100);
    offer(2'd0, 1'b1, 16'd10, 16'd20);
    tick();
    n_checks++; if (bus.o_cmd_addr !== 32'd1040) $display("FAIL single_addr: got %0d want 1040", bus.o_cmd_addr); else n_pass++;
    n_checks++; if (bus.o_cmd_last !== 1'b1) $display("FAIL single_last: got %b want 1", bus.o_cmd_last); else n_pass++;
    n_checks++; if (bus.o_cmd_len !== 8'd7) $display("FAIL single_len: got %0d want 7", bus.o_cmd_len); else n_pass++;
    offer(2'd0, 1'b0, 16'd0, 16'd0);
    bus.o_cmd_ack = 1'b1;
    #1;
    n_checks++; if (bus.i_mofs_ack !== 1'b0) $display("FAIL single_ack_last: got %b want 0", bus.i_mofs_ack); else n_pass++;
    tick();
    bus.o_cmd_ack = 1'b0;
    #1;
    n_checks++; if (bus.o_cmd_rdy !== 1'b0) $display("FAIL single_idle: got %b want 0", bus.o_cmd_rdy); else n_pass++;
    n_checks++; if (bus.i_mofs_ack !== 1'b1) $display("FAIL single_b2b_ack: got %b want 1", bus.i_mofs_ack); else n_pass++;
    tick();
    bus.i_mofs_rdy = 1'b0;
    n_checks++; if (bus.o_cmd_rdy !== 1'b1) $display("FAIL single_b2b_rdy: got %b want 1", bus.o_cmd_rdy); else n_pass++;
    n_checks++; if (bus.o_cmd_addr !== 32'd1000) $display("FAIL single_b2b_addr: got %0d want 1000", bus.o_cmd_addr); else n_pass++;
    n_checks++; if (bus.o_cmd_last !== 1'b1) $display("FAIL single_b2b_last: got %b want 1", bus.o_cmd_last); else n_pass++;
    bus.o_cmd_ack = 1'b1;
    tick();
    bus.o_cmd_ack = 1'b0;
    n_checks++; if (bus.o_cmd_rdy !== 1'b0) $display("FAIL single_end: got %b want 0", bus.o_cmd_rdy); else n_pass++;
    tick();
  endtask

  task automatic test_pad();
    logic [3:0] exp_pad;
    logic [31:0] exp_addr;
`ifdef BOUNDARY_PAD_EN
    exp_pad = 4'b1001;
`else
    exp_pad = 4'b0000;
`endif
    set_cfg(0, 32'd1000, 32'd2, 32'd1, 8'd1, 8'd4, 16'd2);
    offer(2'd0, 1'b0, 16'hFFFF, 16'd0);
    tick();
    bus.i_mofs_rdy = 1'b0;
    bus.o_cmd_ack  = 1'b1;
    exp_addr = 32'd132070;
    for (int r = 0; r < 4; r++) begin
      n_checks++; if (bus.o_cmd_pad !== exp_pad[r]) $display("FAIL pad_row%0d: got %b want %b", r, bus.o_cmd_pad, exp_pad[r]); else n_pass++;
      n_checks++; if (bus.o_cmd_addr !== exp_addr) $display("FAIL pad_addr%0d: got %0d want %0d", r, bus.o_cmd_addr, exp_addr); else n_pass++;
      n_checks++; if (bus.o_cmd_last !== (r == 3)) $display("FAIL pad_last%0d: got %b want %b", r, bus.o_cmd_last, (r == 3)); else n_pass++;
      exp_addr = exp_addr + 32'd2;
      tick();
    end
    bus.o_cmd_ack = 1'b0;
    n_checks++; if (bus.o_cmd_rdy !== 1'b0) $display("FAIL pad_end: got %b want 0", bus.o_cmd_rdy); else n_pass++;
  endtask

  task automatic test_midreset();
    offer(2'd1, 1'b1, 16'd3, 16'd5);
    tick();
    bus.i_mofs_rdy = 1'b0;
    bus.o_cmd_ack  = 1'b1;
    tick();
    bus.o_cmd_ack = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.o_cmd_rdy !== 1'b0) $display("FAIL mrst_rdy: got %b want 0", bus.o_cmd_rdy); else n_pass++;
    n_checks++; if (bus.o_cmd_which !== 1'b0) $display("FAIL mrst_which: got %b want 0", bus.o_cmd_which); else n_pass++;
    n_checks++; if (bus.o_cmd_addr !== 32'd0) $display("FAIL mrst_addr: got %0d want 0", bus.o_cmd_addr); else n_pass++;
    n_checks++; if (bus.o_cmd_len !== 8'd0) $display("FAIL mrst_len: got %0d want 0", bus.o_cmd_len); else n_pass++;
    n_checks++; if (bus.o_cmd_last !== 1'b0) $display("FAIL mrst_last: got %b want 0", bus.o_cmd_last); else n_pass++;
    n_checks++; if (bus.o_cmd_pad !== 1'b0) $display("FAIL mrst_pad: got %b want 0", bus.o_cmd_pad); else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (bus.o_cmd_rdy !== 1'b0) $display("FAIL mrst_dropped: got %b want 0", bus.o_cmd_rdy); else n_pass++;
    offer(2'd1, 1'b0, 16'd3, 16'd5);
    tick();
    bus.i_mofs_rdy = 1'b0;
    n_checks++; if (bus.o_cmd_addr !== 32'd297) $display("FAIL mrst_fresh_addr: got %0d want 297", bus.o_cmd_addr); else n_pass++;
    bus.o_cmd_ack = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.o_cmd_last !== 1'b1) $display("FAIL mrst_fresh_last: got %b want 1", bus.o_cmd_last); else n_pass++;
    tick();
    bus.o_cmd_ack = 1'b0;
    n_checks++; if (bus.o_cmd_rdy !== 1'b0) $display("FAIL mrst_fresh_end: got %b want 0", bus.o_cmd_rdy); else n_pass++;
  endtask

  initial begin
    set_cfg(0, 32'd0, 32'd0, 32'd0, 8'd1, 8'd1, 16'd0);
    set_cfg(1, 32'd100, 32'd64, 32'd1, 8'd4, 8'd3, 16'd0);
    test_reset();
    test_basic();
    test_stall();
    test_single();
    test_pad();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/chunk_addr_looper.md
CHUNK_ADDR_LOOPER -- requirements
Module: chunk_addr_looper

Interface
REQ-001 The block SHALL have parameters: WBW (default TauCfg::WORK_BW), the width of a multidimensional offset element.
REQ-002 The block SHALL have parameters: DIM (default TauCfg::DIM), the number of memory dimensions, at least 2.
REQ-003 The block SHALL have parameters: N_ICFG (default TauCfg::N_ICFG), the number of input configs; ICFG_BW = $clog2(N_ICFG+1).
REQ-004 The block SHALL have parameters: GBW (default TauCfg::GLOBAL_ADDR_BW), the linear DRAM address width.
REQ-005 The block SHALL have parameters: LBW (default 8), the row-length and row-count width.
REQ-006 The block SHALL have these ports; one clock, reset asynchronous and active-high:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_mofs_rdy  in  1  chunk-head offset valid
- i_mofs_ack  out  1  offset accepted
- i_which  in  1  chunk-head selector tag
- i_mofs  in  WBW x DIM  chunk origin
- i_id  in  ICFG_BW  config index
- i_mlinear  in  GBW x N_ICFG  base address per config
- i_mstride  in  GBW x N_ICFG x DIM  address stride per dimension
- i_row_len  in  LBW x N_ICFG  words per row, 1..2^LBW-1
- i_row_cnt  in  LBW x N_ICFG  rows per chunk, 1..2^LBW-1
- i_mbound  in  WBW x N_ICFG  valid row extent along dimension DIM-2
- o_cmd_rdy  out  1  command valid
- o_cmd_ack  in  1  command taken; asserted only when o_cmd_rdy=1
- o_cmd_which  out  1  selector tag of the current chunk
- o_cmd_addr  out  GBW  row start address
- o_cmd_len  out  LBW  row length
- o_cmd_pad  out  1  row out of bounds; zero-fill, no DRAM read
- o_cmd_last  out  1  last row of the chunk

Function
REQ-007 The block SHALL have two states: IDLE and EMIT.
REQ-008 i_mofs_ack SHALL equal i_mofs_rdy AND (state==IDLE), combinationally.
REQ-009 On acceptance, the block SHALL latch which, id, row_len[id], row_cnt[id], mbound[id] and the base address A0 = mlinear[id] + sum over d of (mofs[d] x mstride[id][d]), computed mod 2^GBW with mofs zero-extended. It SHALL then set row r=0 and enter EMIT.
REQ-010 In EMIT, o_cmd_rdy SHALL be 1, with o_cmd_addr = A0 + r x mstride[id][DIM-2] (computed incrementally by adding the stride on each advance), o_cmd_len = latched row_len, o_cmd_last = (r == row_cnt-1), and o_cmd_which = latched which.
REQ-011 Outputs SHALL remain stable while o_cmd_rdy=1 and o_cmd_ack=0.
REQ-012 On o_cmd_ack with o_cmd_last=0, the block SHALL increment r. On o_cmd_ack with o_cmd_last=1, it SHALL return to IDLE.
REQ-013 Latency: offset accepted in cycle N means the first command is valid in cycle N+1; one row per cycle under continuous ack; a new offset can be accepted in the cycle after the last ack.
REQ-014 The block SHALL NOT accept a new offset in the cycle the last ack occurs; i_mofs_ack=0 throughout EMIT.
REQ-015 A chunk with row_cnt=1 SHALL emit exactly one command with o_cmd_last=1.
REQ-016 i_mlinear, i_mstride, i_row_len, i_row_cnt and i_mbound SHALL be quasi-static: they change only while the block is IDLE with i_mofs_rdy=0.

Reset
REQ-017 Asserting i_rst SHALL immediately force: state=IDLE, r=0, o_cmd_rdy=0, o_cmd_which=0, o_cmd_addr=0, o_cmd_len=0, o_cmd_pad=0, o_cmd_last=0.
REQ-018 Reset during EMIT SHALL drop the in-flight chunk with no further commands.
REQ-019 After reset deasserts, i_mofs_ack SHALL follow i_mofs_rdy.

Configuration
REQ-020 With BOUNDARY_PAD_EN defined, o_cmd_pad SHALL equal ((mofs[DIM-2] + r) mod 2^WBW >= latched mbound), evaluated as unsigned, so that negative offsets also pad. Padded rows SHALL still be emitted and handshaken.
REQ-021 With BOUNDARY_PAD_EN undefined, o_cmd_pad SHALL be tied to 0, i_mbound SHALL be ignored, and no comparator SHALL be present.

Verification
REQ-022 Scenario "basic": DIM=2, mofs={3,5}, mlinear=100, mstride={64,1}, row_len=4, row_cnt=3 -> addr 100+3*64+5=297, then 361, then 425; len=4; last only on the third row; ack returns to 1 the following cycle.
REQ-023 Scenario "stall": same chunk as "basic" with o_cmd_ack held 0 for 5 cycles on row 1 -> addr=361 and last=0 stable; exactly 3 commands total.
REQ-024 Scenario "single": row_cnt=1 -> one command with last=1; a back-to-back offset is accepted on the next cycle, with first command valid at cycle+1.
REQ-025 Scenario "pad" (BOUNDARY_PAD_EN): mofs[DIM-2]=-1 (all ones), mbound=2, row_cnt=4 -> pad=1,0,0,1. Without the macro -> pad=0,0,0,0.
REQ-026 Scenario "reset": assert i_rst mid-EMIT at row 1 -> o_cmd_rdy=0 in the same cycle, all outputs 0; a fresh chunk after release starts at r=0.
